// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU A-operand sequencer.
// Default array geometry, FSM states and the row payload type.
package tpu_pkg;

  localparam int TPU_DIM     = 8;
  localparam int TPU_BITS_AB = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } seq_state_t;

  // Cycles needed to push a skewed DIM x DIM tile through the array.
  function automatic int drain_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

  localparam int DRAIN_CYCLES = drain_cycles(TPU_DIM);

  typedef logic signed [TPU_BITS_AB-1:0] row_t [TPU_DIM-1:0];

endpackage

// File: rtl/tpu_seq_counter.sv
// Up-counter with enable, synchronous clear and a terminal-count flag.
// Wraps to zero on the enabled terminal cycle so the owner never sees overflow.
module tpu_seq_counter #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

  assign terminal = (count == TERM);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/tpu_a_sequencer.sv
// Loads DIM rows of A into the A memory, then enables its shift for 2*DIM-1
// non-stalled cycles to drain the skewed stream into the MAC array.
module tpu_a_sequencer
  import tpu_pkg::*;
#(
  parameter int BITS_AB = TPU_BITS_AB,
  parameter int DIM     = TPU_DIM
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       stall,
  output logic                       busy,
  output logic                       done,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  logic signed [BITS_AB-1:0]  row_data [DIM-1:0],
  output logic                       memA_WrEn,
  output logic [$clog2(DIM)-1:0]     memA_Arow,
  output logic signed [BITS_AB-1:0]  memA_Ain [DIM-1:0],
  output logic                       memA_en
);

  localparam int ROW_W   = $clog2(DIM);
  localparam int DRAIN_W = $clog2(2 * DIM);

  seq_state_t         state;
  logic [ROW_W-1:0]   row_cnt;
  logic               row_last;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_last;
  logic               handshake;
  logic               row_inc;
  logic               drain_inc;

  assign row_ready = (state == LOAD);
  assign handshake = row_valid && row_ready;
  assign row_inc   = handshake && !abort;
  assign drain_inc = (state == STREAM) && !stall && !abort;

  tpu_seq_counter #(
    .WIDTH    (ROW_W),
    .TERMINAL (DIM - 1)
  ) u_row_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .en       (row_inc),
    .count    (row_cnt),
    .terminal (row_last)
  );

  tpu_seq_counter #(
    .WIDTH    (DRAIN_W),
    .TERMINAL (drain_cycles(DIM) - 1)
  ) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .en       (drain_inc),
    .count    (drain_cnt),
    .terminal (drain_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      memA_WrEn <= 1'b0;
      memA_en   <= 1'b0;
      memA_Arow <= '0;
      // NOTE: the Ain staging register is reset so the memory never sees stale data on reset.
      memA_Ain  <= '{default: '0};
    end else begin
      memA_WrEn <= 1'b0;
      memA_en   <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        // Rows already written stay in the A memory; only the sequencer is cancelled.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            if (handshake) begin
              memA_WrEn <= 1'b1;
              memA_Arow <= row_cnt;
              memA_Ain  <= row_data;
              if (row_last) state <= STREAM;
            end
          end
          STREAM: begin
            if (!stall) begin
              memA_en <= 1'b1;
              if (drain_last) state <= DONE;
            end
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tpu_a_sequencer.sv
// Scoreboard bench for tpu_a_sequencer: host rows are queued on handshake and
// matched against memA writes; per-job timing is compared with expected cycles.
module tb_tpu_a_sequencer;
  import tpu_pkg::*;

  localparam int DIM = TPU_DIM;

  logic       clk = 1'b0;
  logic       rst, start, abort, stall;
  logic       busy, done, row_valid, row_ready, memA_WrEn, memA_en;
  logic [2:0] memA_Arow;
  row_t       row_data, memA_Ain;

  always #5 clk = ~clk;

  tpu_a_sequencer #(.BITS_AB(TPU_BITS_AB), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .memA_WrEn (memA_WrEn),
    .memA_Arow (memA_Arow),
    .memA_Ain  (memA_Ain),
    .memA_en   (memA_en)
  );

  typedef struct {
    int   arow;
    row_t data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;

  int rdy_n, rdy_f, rdy_l, wr_n, wr_f, wr_l, en_n, en_f, en_l;
  int done_n, done_c, busy_n, busy_f, busy_l;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input row_t r);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < DIM; j++) v[j*8 +: 8] = r[j];
    return v;
  endfunction

  function automatic row_t make_row(input int mode, input int idx);
    row_t r;
    for (int j = 0; j < DIM; j++) r[j] = 8'((mode == 0) ? idx + 1 : idx + 1 + 16 * j);
    return r;
  endfunction

  task automatic note(input int t, inout int n, inout int f, inout int l);
    n++;
    if (f < 0) f = t;
    l = t;
  endtask

  // mode: 0 continuous, 1 gapped, 2 stall, 3 abort, 4 start-while-busy,
  //       5 start&abort in IDLE, 6 rst during LOAD
  task automatic run_job(input int mode, input int ncyc);
    int  hidx;
    wr_t e;
    hidx = 0;
    rdy_n = 0; rdy_f = -1; rdy_l = -1; wr_n = 0; wr_f = -1; wr_l = -1;
    en_n = 0; en_f = -1; en_l = -1; done_n = 0; done_c = -1;
    busy_n = 0; busy_f = -1; busy_l = -1;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      if (row_ready) note(t, rdy_n, rdy_f, rdy_l);
      if (memA_en)   note(t, en_n, en_f, en_l);
      if (busy)      note(t, busy_n, busy_f, busy_l);
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = t;
      end
      if (memA_WrEn) begin
        note(t, wr_n, wr_f, wr_l);
        if (sb.size() == 0) begin
          check("wr_unexpected", 64'(memA_WrEn), 64'(0));
        end else begin
          e = sb.pop_front();
          check($sformatf("m%0d.wr_arow", mode), 64'(memA_Arow), 64'(e.arow));
          check($sformatf("m%0d.wr_ain", mode), pack(memA_Ain), pack(e.data));
        end
      end
      if (mode == 6 && t == 6) begin
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.ready", 64'(row_ready), 64'(0));
        check("rst.wren", 64'(memA_WrEn), 64'(0));
        check("rst.en", 64'(memA_en), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.arow", 64'(memA_Arow), 64'(0));
        check("rst.ain", pack(memA_Ain), 64'(0));
      end
      start     = (t == 0) || (mode == 4 && t == 4);
      abort     = (mode == 3 && t == 14) || (mode == 5 && t == 0);
      stall     = (mode == 2 && t >= 12 && t <= 14);
      rst       = (mode == 6 && t == 5);
      row_valid = (mode == 1) ? (t % 2 == 1) : 1'b1;
      row_data  = make_row(mode, hidx);
      if (row_valid && row_ready && !rst && !abort) begin
        e.arow = hidx;
        e.data = row_data;
        sb.push_back(e);
        hidx++;
      end
    end
  endtask

  task automatic expect_job(input string name,
                            input int e_rdy_n, input int e_rdy_f, input int e_rdy_l,
                            input int e_wr_n, input int e_wr_f, input int e_wr_l,
                            input int e_en_n, input int e_en_f, input int e_en_l,
                            input int e_done_n, input int e_done_c,
                            input int e_busy_n, input int e_busy_f, input int e_busy_l);
    check({name, ".rdy_n"},  64'(rdy_n),  64'(e_rdy_n));
    check({name, ".rdy_f"},  64'(rdy_f),  64'(e_rdy_f));
    check({name, ".rdy_l"},  64'(rdy_l),  64'(e_rdy_l));
    check({name, ".wr_n"},   64'(wr_n),   64'(e_wr_n));
    check({name, ".wr_f"},   64'(wr_f),   64'(e_wr_f));
    check({name, ".wr_l"},   64'(wr_l),   64'(e_wr_l));
    check({name, ".en_n"},   64'(en_n),   64'(e_en_n));
    check({name, ".en_f"},   64'(en_f),   64'(e_en_f));
    check({name, ".en_l"},   64'(en_l),   64'(e_en_l));
    check({name, ".done_n"}, 64'(done_n), 64'(e_done_n));
    check({name, ".done_c"}, 64'(done_c), 64'(e_done_c));
    check({name, ".busy_n"}, 64'(busy_n), 64'(e_busy_n));
    check({name, ".busy_f"}, 64'(busy_f), 64'(e_busy_f));
    check({name, ".busy_l"}, 64'(busy_l), 64'(e_busy_l));
    check({name, ".sb_left"}, 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0; row_valid = 1'b0;
    row_data = make_row(0, -1);
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check("reset.ready", 64'(row_ready), 64'(0));
    check("reset.wren", 64'(memA_WrEn), 64'(0));
    check("reset.en", 64'(memA_en), 64'(0));
    check("reset.arow", 64'(memA_Arow), 64'(0));
    check("reset.ain", pack(memA_Ain), 64'(0));
    rst = 1'b0;

    run_job(0, 40);
    expect_job("cont", 8, 1, 8, 8, 2, 9, 15, 10, 24, 1, 25, 24, 1, 24);
    run_job(1, 45);
    expect_job("gap", 15, 1, 15, 8, 2, 16, 15, 17, 31, 1, 32, 31, 1, 31);
    run_job(2, 40);
    expect_job("stall", 8, 1, 8, 8, 2, 9, 15, 10, 27, 1, 28, 27, 1, 27);
    run_job(3, 40);
    expect_job("abort", 8, 1, 8, 8, 2, 9, 5, 10, 14, 0, -1, 14, 1, 14);
    run_job(0, 40);
    expect_job("rerun", 8, 1, 8, 8, 2, 9, 15, 10, 24, 1, 25, 24, 1, 24);
    run_job(4, 40);
    expect_job("busy_start", 8, 1, 8, 8, 2, 9, 15, 10, 24, 1, 25, 24, 1, 24);
    run_job(5, 8);
    expect_job("start_abort", 0, -1, -1, 0, -1, -1, 0, -1, -1, 0, -1, 0, -1, -1);
    run_job(6, 12);
    expect_job("rst_load", 5, 1, 5, 4, 2, 5, 0, -1, -1, 0, -1, 5, 1, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
